dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the load/store requests issued by the pipeline's memory stage. It accepts one word-aligned read or write at a time, holds the requester in stall for a fixed programmable latency, then commits the write or returns read data with a one-cycle `done` pulse. It replaces the single-cycle data array behind the memory stage so that stall handling can be exercised.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind the memory stage.
// Accepts one word-aligned 16-bit read or write at a time, holds the
// requester in stall for LATENCY cycles, then commits the write or
// returns read data together with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active low
//   req_rd    read request (held until done is seen)
//   req_wr    write request (held until done is seen)
//   addr      byte address, bit 0 must be 0; high bits alias
//   data_in   write data
//   data_out  registered read data, valid while done=1, else holds
//   done      registered one-cycle completion pulse
//   stall     combinational, requester must hold its request
//   err       registered one-cycle pulse for an illegal request
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    localparam int WORDS = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // Latched request; the live inputs are not used after acceptance.
    logic                 op_wr;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]          wdata;

    logic [15:0] mem [WORDS];

    logic any_req;
    logic legal;
    logic illegal;
    logic accept;
    logic commit;

    // Address bits above the word index only alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_BITS+1];

    assign any_req = req_rd | req_wr;
    assign legal   = (req_rd ^ req_wr) & ~addr[0];
    assign illegal = any_req & ~legal;

    // Next-state, counter and strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                // Illegal requests stall for their own cycle only.
                stall = any_req;
                if (legal) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                // Still-held request is ignored here.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= 16'h0000;
            op_wr    <= 1'b0;
            idx      <= '0;
            wdata    <= 16'h0000;
        end else begin
            done <= commit;
            err  <= (state == IDLE) && illegal;
            if (accept) begin
                op_wr <= req_wr;
                idx   <= addr[ADDR_BITS:1];
                wdata <= data_in;
            end
            if (commit && !op_wr) begin
                data_out <= mem[idx];
            end
        end
    end

    // Write commits only on the final BUSY edge, so a reset
    // during BUSY discards the pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (commit && op_wr) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder
// against a word-array reference model kept in the bench.
module tb_dmem_responder;

    localparam int AB  = 8;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [0:(1<<AB)-1];
    logic [15:0] dout_m;

    dmem_responder #(
        .ADDR_BITS(AB),
        .LATENCY  (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_rd  (req_rd),
        .req_wr  (req_wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .done    (done),
        .stall   (stall),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % (1 << AB);
    endfunction

    task automatic model_reset();
        foreach (mem_m[i]) mem_m[i] = 16'h0000;
        dout_m = 16'h0000;
    endtask

    // One legal access; cycle 0 is the first cycle the request is seen.
    task automatic access(input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input bit drop,
                          input string tag);
        logic exp_stall;
        logic exp_done;
        @(negedge clk);
        req_rd  = !wr;
        req_wr  = wr;
        addr    = a;
        data_in = d;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_stall = (c <= LAT);
            exp_done  = (c == LAT + 1);
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL %s stall c%0d: got %b exp %b",
                         tag, c, stall, exp_stall);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done c%0d: got %b exp %b",
                         tag, c, done, exp_done);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err c%0d: got %b exp 0", tag, c, err);
            end
        end
        if (wr) mem_m[widx(a)] = d;
        else    dout_m = mem_m[widx(a)];
        checks++;
        if (data_out !== dout_m) begin
            errors++;
            $display("FAIL %s data_out: got %h exp %h",
                     tag, data_out, dout_m);
        end
        if (drop) begin
            @(negedge clk);
            req_rd = 1'b0;
            req_wr = 1'b0;
            #1;
            checks++;
            if (stall !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s after-resp: got stall %b done %b exp 0 0",
                         tag, stall, done);
            end
        end
    endtask

    task automatic illegal(input bit rd, input bit wr,
                           input logic [15:0] a, input string tag);
        @(negedge clk);
        req_rd  = rd;
        req_wr  = wr;
        addr    = a;
        data_in = 16'hFFFF;
        #1;
        checks++;
        if (stall !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s c0: got stall %b err %b exp 1 0",
                     tag, stall, err);
        end
        @(negedge clk);
        req_rd = 1'b0;
        req_wr = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s c1: got err %b stall %b done %b exp 1 0 0",
                     tag, err, stall, done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s c2: got err %b done %b stall %b exp 0 0 0",
                     tag, err, done, stall);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        model_reset();
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got done %b err %b stall %b exp 0 0 0",
                     done, err, stall);
        end
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset data_out: got %h exp 0000", data_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_read_basic();
        access(1'b0, 16'h0010, 16'h0000, 1'b1, "rd_0010");
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL rd_0010 const: got %h exp 0000", data_out);
        end
    endtask

    task automatic test_write_read();
        access(1'b1, 16'h0020, 16'hBEEF, 1'b1, "wr_0020");
        access(1'b0, 16'h0020, 16'h0000, 1'b1, "rd_0020");
        checks++;
        if (data_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_0020 const: got %h exp beef", data_out);
        end
    endtask

    task automatic test_wrap();
        access(1'b1, 16'h0002, 16'h1234, 1'b1, "wr_0002");
        access(1'b0, 16'h0202, 16'h0000, 1'b1, "rd_0202");
        checks++;
        if (data_out !== 16'h1234) begin
            errors++;
            $display("FAIL wrap const: got %h exp 1234", data_out);
        end
    endtask

    task automatic test_illegal();
        illegal(1'b1, 1'b0, 16'h0011, "ill_odd");
        illegal(1'b1, 1'b1, 16'h0040, "ill_both");
        access(1'b0, 16'h0040, 16'h0000, 1'b1, "rd_0040");
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL ill_both array: got %h exp 0000", data_out);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        req_wr  = 1'b1;
        addr    = 16'h0030;
        data_in = 16'h5555;
        @(negedge clk);
        req_wr = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || stall !== 1'b0
            || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrst outs: got done %b err %b stall %b data %h exp 0",
                     done, err, stall, data_out);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrst late done: got %b exp 0", done);
        end
        access(1'b0, 16'h0030, 16'h0000, 1'b1, "rd_0030");
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrst array: got %h exp 0000", data_out);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 16'h0050, 16'hA5A5, 1'b0, "b2b_wr0");
        access(1'b1, 16'h0052, 16'h5A5A, 1'b0, "b2b_wr1");
        access(1'b0, 16'h0050, 16'h0000, 1'b0, "b2b_rd0");
        access(1'b0, 16'h0052, 16'h0000, 1'b1, "b2b_rd1");
    endtask

    task automatic test_random();
        logic [15:0] a;
        bit          wr;
        bit          both;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                both = ($urandom_range(0, 1) == 1);
                if (both) begin
                    a = 16'($urandom());
                    illegal(1'b1, 1'b1, a, "rnd_ill_both");
                end else begin
                    a  = 16'($urandom()) | 16'h0001;
                    wr = ($urandom_range(0, 1) == 1);
                    illegal(!wr, wr, a, "rnd_ill_odd");
                end
            end else begin
                a  = (16'($urandom()) & 16'hFE00)
                   | (16'($urandom_range(0, 15)) << 1);
                wr = ($urandom_range(0, 1) == 1);
                access(wr, a, 16'($urandom()),
                       ($urandom_range(0, 1) == 1), "rnd");
            end
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_read();
        test_wrap();
        test_illegal();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
